// File: rtl/decoder_pkg.sv
// Shared types for the instruction decode queue: decoded-half record, FSM states,
// and bit positions of the native fields inside one 32-bit half word.
package decoder_pkg;
  localparam int DEC_ADDR_W = 20;
  localparam logic [7:0] EXTOP_CODE = 8'h3f;

  typedef enum logic {S_LEFT = 1'b0, S_RIGHT = 1'b1} dec_state_e;

  typedef struct packed {
    logic                  tkk;
    logic                  pe;
    logic [3:0]            ir;
    logic [7:0]            op;
    logic                  extop;
    logic [DEC_ADDR_W-1:0] addr;
  } decoded_half_t;

  // Native fields sit at the same place in either half (bit 1 = lsb of the half).
  localparam int HALF_W  = 32;
  localparam int IR_HI   = 32;
  localparam int IR_LO   = 29;
  localparam int BOP_HI  = 28;
  localparam int BOP_LO  = 21;
  localparam int XOP_HI  = 20;
  localparam int XOP_LO  = 13;
  localparam int ADDR_HI = 20;
  localparam int ADDR_LO = 1;
endpackage

// File: rtl/instr_decode_queue_if.sv
// Fetch-side and dispatch-side handshake bundle of the instruction decode queue.
interface instr_decode_queue_if #(parameter int ADDR_W = 20);
  logic              in_valid;
  logic              in_ready;
  logic [64:1]       in_word;
  logic              in_pe;
  logic              in_rhalf;
  logic              out_valid;
  logic              out_ready;
  logic              out_tkk;
  logic              out_pe;
  logic [3:0]        out_ir;
  logic [7:0]        out_op;
  logic              out_extop;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_word, in_pe, in_rhalf, out_ready,
    input  in_ready, out_valid, out_tkk, out_pe, out_ir, out_op, out_extop, out_addr
  );
  modport slave (
    input  in_valid, in_word, in_pe, in_rhalf, out_ready,
    output in_ready, out_valid, out_tkk, out_pe, out_ir, out_op, out_extop, out_addr
  );
endinterface

// File: rtl/decode_half.sv
// Combinational decode of one half of a 64-bit instruction word.
// besm6 paths exist only when MICROBESM_PE_DECODE_EN is defined.
module decode_half
  import decoder_pkg::*;
(
  input  logic          [64:1] word,
  input  logic                 pe,
  input  logic                 tkk,
  output decoded_half_t        dec
);
  logic [HALF_W:1] h;
  logic [7:0]      bop;

  always_comb begin
    h         = tkk ? word[32:1] : word[64:33];
    bop       = h[BOP_HI:BOP_LO];
    dec       = '0;
    dec.tkk   = tkk;
    dec.pe    = pe;
    dec.ir    = h[IR_HI:IR_LO];
    dec.extop = !pe && (bop == EXTOP_CODE);
    dec.op    = dec.extop ? h[XOP_HI:XOP_LO] : bop;
    dec.addr  = h[ADDR_HI:ADDR_LO];
`ifdef MICROBESM_PE_DECODE_EN
    // besm6 halves are not symmetric, so index the full word directly.
    if (pe) begin
      dec.extop = 1'b0;
      if (!tkk) begin
        dec.ir = {word[64], word[59:57]};
        if (word[56]) begin
          dec.op   = {word[56:52], 3'b000};
          dec.addr = {5'd0, word[51:37]};
        end else begin
          dec.op   = word[56:49];
          dec.addr = {5'd0, {3{word[55]}}, word[48:37]};
        end
      end else begin
        dec.ir = word[36:33];
        if (word[32]) begin
          dec.op   = {word[32:28], 3'b000};
          dec.addr = {5'd0, word[27:13]};
        end else begin
          dec.op   = word[32:25];
          dec.addr = {5'd0, {3{word[31]}}, word[24:13]};
        end
      end
    end
`endif
  end
endmodule

// File: rtl/instr_decode_queue.sv
// DEPTH-entry instruction queue emitting one decoded half per cycle (left, then right).
// MICROBESM_PE_DECODE_EN enables besm6 decode; otherwise in_pe is ignored.
module instr_decode_queue
  import decoder_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 20
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  instr_decode_queue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [64:1]      q_word [DEPTH];
  logic [DEPTH-1:0] q_pe, q_rhalf;
  logic [PTR_W-1:0] wptr, rptr, rptr_nx;
  logic [CNT_W-1:0] count;

  dec_state_e    state, state_n;
  decoded_half_t dec, out_q;
  logic          out_valid;
  logic          in_pe_s, push, pop, load, head_vld, nxt_rhalf;

`ifdef MICROBESM_PE_DECODE_EN
  assign in_pe_s = bus.in_pe;
`else
  logic unused_pe;
  assign unused_pe = bus.in_pe;
  assign in_pe_s   = 1'b0;
`endif

  assign bus.in_ready = rst_n && (count < CNT_W'(DEPTH)) && !flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign head_vld     = (count != '0);
  assign load         = head_vld && (!out_valid || bus.out_ready);
  assign pop          = load && (state == S_RIGHT);
  assign rptr_nx      = rptr + PTR_W'(1);
  // With a single queued word the successor is whatever arrives this cycle.
  assign nxt_rhalf    = (count == CNT_W'(1)) ? (push && bus.in_rhalf) : q_rhalf[rptr_nx];

  decode_half u_dec (
    .word (q_word[rptr]),
    .pe   (q_pe[rptr]),
    .tkk  (state == S_RIGHT),
    .dec  (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LEFT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush)
      state_n = S_LEFT;
    else if (!head_vld)
      state_n = (push && bus.in_rhalf) ? S_RIGHT : S_LEFT;
    else if (load)
      state_n = (state == S_LEFT || nxt_rhalf) ? S_RIGHT : S_LEFT;
  end

  always_ff @(posedge clk) begin
    if (push) q_word[wptr] <= bus.in_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      q_pe    <= '0;
      q_rhalf <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_pe[wptr]    <= in_pe_s;
        q_rhalf[wptr] <= bus.in_rhalf;
        wptr          <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr_nx;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_tkk   = out_q.tkk;
  assign bus.out_pe    = out_q.pe;
  assign bus.out_ir    = out_q.ir;
  assign bus.out_op    = out_q.op;
  assign bus.out_extop = out_q.extop;
  assign bus.out_addr  = ADDR_W'(out_q.addr);
endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed + random bench for instr_decode_queue against a half-stream reference model.
module tb_instr_decode_queue;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  instr_decode_queue_if #(.ADDR_W(ADDR_W)) bus();

  instr_decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [64:1] w;
    logic        pe;
    logic        tkk;
  } half_t;

  // Model: halves not yet loaded, words whose right half is not yet loaded, output register.
  half_t       pend[$];
  int          wcnt = 0;
  logic        m_ov = 1'b0;
  logic [34:0] m_reg = '0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [34:0] exp_half(logic [64:1] w, logic pe, logic tkk);
    logic [3:0]  ir;
    logic [7:0]  op, bop, xop;
    logic        ext;
    logic [19:0] a;
    if (!tkk) begin
      ir = w[64:61]; bop = w[60:53]; xop = w[52:45]; a = w[52:33];
    end else begin
      ir = w[32:29]; bop = w[28:21]; xop = w[20:13]; a = w[20:1];
    end
    ext = !pe && (bop == 8'h3f);
    op  = ext ? xop : bop;
`ifdef MICROBESM_PE_DECODE_EN
    if (pe) begin
      ext = 1'b0;
      if (!tkk) begin
        ir = {w[64], w[59:57]};
        if (w[56]) begin op = {w[56:52], 3'b000}; a = {5'd0, w[51:37]}; end
        else       begin op = w[56:49]; a = {5'd0, {3{w[55]}}, w[48:37]}; end
      end else begin
        ir = w[36:33];
        if (w[32]) begin op = {w[32:28], 3'b000}; a = {5'd0, w[27:13]}; end
        else       begin op = w[32:25]; a = {5'd0, {3{w[31]}}, w[24:13]}; end
      end
    end
`endif
    return {tkk, pe, ir, op, ext, a};
  endfunction

  function automatic logic [64:1] rword();
    logic [64:1] w;
    w = {$urandom(), $urandom()};
    if ($urandom_range(0, 2) == 0) w[60:53] = 8'h3f;
    if ($urandom_range(0, 2) == 0) w[28:21] = 8'h3f;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    wcnt  = 0;
    m_ov  = 1'b0;
    m_reg = '0;
  endtask

  task automatic model_edge();
    half_t h;
    logic  acc;
    logic  pe_s;
    acc = bus.in_valid && (wcnt < DEPTH) && !flush;
`ifdef MICROBESM_PE_DECODE_EN
    pe_s = bus.in_pe;
`else
    pe_s = 1'b0;
`endif
    if (flush) begin
      pend.delete();
      wcnt = 0;
      m_ov = 1'b0;
    end else begin
      if (pend.size() > 0 && (!m_ov || bus.out_ready)) begin
        h     = pend.pop_front();
        m_reg = exp_half(h.w, h.pe, h.tkk);
        m_ov  = 1'b1;
        if (h.tkk) wcnt--;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
      if (acc) begin
        wcnt++;
        if (!bus.in_rhalf) pend.push_back('{bus.in_word, pe_s, 1'b0});
        pend.push_back('{bus.in_word, pe_s, 1'b1});
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ":in_ready"}, 64'(bus.in_ready), 64'(rst_n && (wcnt < DEPTH) && !flush));
    chk({tag, ":out_valid"}, 64'(bus.out_valid), 64'(m_ov));
    if (m_ov)
      chk({tag, ":fields"}, 64'({bus.out_tkk, bus.out_pe, bus.out_ir, bus.out_op,
                                 bus.out_extop, bus.out_addr}), 64'(m_reg));
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic step(input string tag, input logic iv, input logic [64:1] w, input logic pe,
                      input logic rh, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_word   = w;
    bus.in_pe     = pe;
    bus.in_rhalf  = rh;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    check_outs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input string tag, input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic [64:1] w;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.in_pe     = 1'b0;
    bus.in_rhalf  = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_fields", 64'({bus.out_tkk, bus.out_pe, bus.out_ir, bus.out_op, bus.out_extop,
                           bus.out_addr}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    idle("post_rst", 2, 1'b1);

    // native word: left ir=3 op=12 addr=0ABCD, right ir=5 extended op 47
    w = '0;
    w[64:61] = 4'd3; w[60:53] = 8'h12; w[52:33] = 20'h0ABCD;
    w[32:29] = 4'd5; w[28:21] = 8'h3f; w[20:13] = 8'h47; w[12:1] = 12'h5a5;
    step("nat_push", 1'b1, w, 1'b0, 1'b0, 1'b1, 1'b0);
    step("nat_lat", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("nat_left_valid", 64'(bus.out_valid), 64'd1);
    chk("nat_left_op", 64'(bus.out_op), 64'h12);
    chk("nat_left_ir", 64'(bus.out_ir), 64'd3);
    chk("nat_left_addr", 64'(bus.out_addr), 64'h0ABCD);
    chk("nat_left_extop", 64'(bus.out_extop), 64'd0);
    step("nat_l", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("nat_right_tkk", 64'(bus.out_tkk), 64'd1);
    chk("nat_right_op", 64'(bus.out_op), 64'h47);
    chk("nat_right_extop", 64'(bus.out_extop), 64'd1);
    chk("nat_right_addr", 64'(bus.out_addr), 64'(w[20:1]));
    idle("nat_tail", 3, 1'b1);

    // besm6 word: long-address left half, right half with bop=3f (never extended under pe)
    w = '0;
    w[64] = 1'b1; w[59:57] = 3'b010; w[56:52] = 5'b10011; w[51:37] = 15'h1234;
    w[36:33] = 4'd9; w[32:25] = 8'h3f; w[24:13] = 12'hf0e;
    step("pe_push", 1'b1, w, 1'b1, 1'b0, 1'b1, 1'b0);
    step("pe_lat", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef MICROBESM_PE_DECODE_EN
    chk("pe_left_op", 64'(bus.out_op), 64'h98);
    chk("pe_left_addr", 64'(bus.out_addr), 64'h01234);
    chk("pe_left_extop", 64'(bus.out_extop), 64'd0);
`endif
    step("pe_l", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("pe_tail", 3, 1'b1);

    // rhalf word followed back-to-back by a normal word: R1, L2, R2 with no bubble
    step("rh_push1", 1'b1, rword(), 1'b0, 1'b1, 1'b1, 1'b0);
    step("rh_push2", 1'b1, rword(), 1'b0, 1'b0, 1'b1, 1'b0);
    idle("rh_drain", 5, 1'b1);

    // fill with consumer stalled, then drain (pointer wrap)
    for (int i = 0; i < DEPTH + 3; i++) step("fill", 1'b1, rword(), 1'($urandom), 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    idle("full_hold", 3, 1'b0);
    idle("full_drain", 2 * DEPTH + 3, 1'b1);

    // flush with queue full, output valid and a word offered
    for (int i = 0; i < DEPTH + 2; i++) step("pre_flush", 1'b1, rword(), 1'b0, 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, rword(), 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    step("post_flush", 1'b1, rword(), 1'b0, 1'b0, 1'b1, 1'b0);
    idle("post_flush_drain", 4, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), rword(), 1'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0));

    // asynchronous reset between edges while streaming
    for (int i = 0; i < 3; i++) step("pre_arst", 1'b1, rword(), 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_fields", 64'({bus.out_tkk, bus.out_pe, bus.out_ir, bus.out_op, bus.out_extop,
                            bus.out_addr}), 64'd0);
    model_reset();
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    step("arst_push", 1'b1, rword(), 1'b0, 1'b0, 1'b1, 1'b0);
    idle("arst_drain", 4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
